// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    // Frame phases of the transmitter.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    // Parity-mode selectors.
    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    // Parity bit for a zero-extended payload; odd parity inverts the XOR reduction.
    function automatic logic parity_of(input logic [8:0] payload, input logic [1:0] mode);
        return (^payload) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud-rate divider: counts 0..CLKS_PER_BIT-1 and pulses tick on the last count.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_baud_cnt: CLKS_PER_BIT must be >= 2");
    end

    logic [CNT_W-1:0] cnt;

    // Free-running divider held at zero while cleared, wrapping on the terminal count.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: latches a parallel payload and shifts out start, data,
// optional parity and stop bits on a registered, idle-high serial line.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int         DATA_W       = 8,
    parameter int         CLKS_PER_BIT = 16,
    parameter logic [1:0] PARITY_MODE  = PAR_NONE,
    parameter int         STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_select,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              serial_out,
    output logic              busy
);

    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
        $error("uart_tx_serializer: DATA_W must be in 5..9");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("uart_tx_serializer: CLKS_PER_BIT must be >= 2");
    end
    if (PARITY_MODE != PAR_NONE && PARITY_MODE != PAR_EVEN && PARITY_MODE != PAR_ODD) begin : g_bad_parity
        $error("uart_tx_serializer: PARITY_MODE must be PAR_NONE, PAR_EVEN or PAR_ODD");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end

    localparam bit         HAS_PARITY = (PARITY_MODE != PAR_NONE);
    localparam logic [3:0] LAST_DATA  = 4'(DATA_W - 1);
    localparam logic [3:0] LAST_STOP  = 4'(STOP_BITS - 1);

    tx_state_e         state, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [3:0]        bit_cnt, bit_cnt_d;
    logic              par_q, par_d;
    logic              line_d;
    logic              tick;
    logic              accept;

    assign accept = tx_valid && tx_ready;

    // The divider only runs while a frame is on the line, so every frame starts at count zero.
    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .reset (reset),
        .clear (state == IDLE),
        .tick  (tick)
    );

    // State register; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state: phases advance only on a baud tick, except acceptance out of IDLE.
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:   if (accept) state_d = START;
            START:  if (tick) state_d = DATA;
            DATA:   if (tick && bit_cnt == LAST_DATA) state_d = HAS_PARITY ? PARITY : STOP;
            PARITY: if (tick) state_d = STOP;
            STOP:   if (tick && bit_cnt == LAST_STOP) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: handshake, busy flag and the level the line takes after the next edge.
    always_comb begin
        tx_ready = (state == IDLE) && uart_select && !reset;
        busy     = (state != IDLE);
        line_d   = 1'b1;
        unique case (state_d)
            IDLE:    line_d = 1'b1;
            START:   line_d = 1'b0;
            DATA:    line_d = shift_d[0];
            PARITY:  line_d = par_q;
            STOP:    line_d = 1'b1;
            default: line_d = 1'b1;
        endcase
    end

    // Datapath next values: load on acceptance, shift right per data bit, count bits per phase.
    always_comb begin
        shift_d   = shift_q;
        par_d     = par_q;
        bit_cnt_d = bit_cnt;
        if (state == IDLE && accept) begin
            shift_d = tx_data;
            par_d   = parity_of(9'(tx_data), PARITY_MODE);
        end else if (state == DATA && tick) begin
            shift_d = shift_q >> 1;
        end
        if (state_d != state) begin
            bit_cnt_d = '0;
        end else if (tick && (state == DATA || state == STOP)) begin
            bit_cnt_d = bit_cnt + 1'b1;
        end
    end

    // Datapath registers and the registered serial line.
    // NOTE: the shift register is cleared on reset too, so no stale payload survives an abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q    <= '0;
            par_q      <= 1'b0;
            bit_cnt    <= '0;
            serial_out <= 1'b1;
        end else begin
            shift_q    <= shift_d;
            par_q      <= par_d;
            bit_cnt    <= bit_cnt_d;
            serial_out <= line_d;
        end
    end

endmodule
